sdram_burst_sched: RTL

- Schedules SDRAM burst transfers between the camera write FIFO and the display read FIFO of the frame-buffer path.
- Watches both FIFO fill levels, picks a burst direction (round-robin when both are eligible), and issues one burst command at a time to the SDRAM controller core.
- Keeps the per-direction burst address pointers and wraps them at the frame end.
- Pulses frame_write_done / frame_read_done for the bank switcher.

---
 rtl/sdram_burst_sched.sv | 97 +++++++++
 1 files changed

// File: rtl/sdram_burst_sched.sv
// sdram_burst_sched: arbitrates single SDRAM bursts between the camera write FIFO and display read FIFO, keeping wrapping frame pointers.
module sdram_burst_sched #(
  parameter int ADDR_W = 22,
  parameter int LEN_W  = 9,
  parameter int FIFO_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  input  logic [FIFO_W-1:0] wr_fifo_usedw,
  input  logic [FIFO_W-1:0] rd_fifo_usedw,
  input  logic              rd_enable,
  input  logic [LEN_W-1:0]  wr_length,
  input  logic [LEN_W-1:0]  rd_length,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] wr_max_addr,
  input  logic              wr_load,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] rd_max_addr,
  input  logic              rd_load,
  output logic              cmd_wr_req,
  output logic              cmd_rd_req,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_ack,
  input  logic              cmd_done,
  output logic              frame_write_done,
  output logic              frame_read_done,
  output logic              busy
);
  localparam int CW = (FIFO_W > LEN_W) ? FIFO_W : LEN_W;
  typedef enum logic [2:0] {INIT, ARB, WR_REQ, RD_REQ, WR_BUSY, RD_BUSY} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic last_rd, wr_pend, rd_pend;
  logic wr_ok, rd_ok, wr_apply, rd_apply, arb, go_wr, go_rd;
  logic wr_upd, rd_upd, wr_wrap, rd_wrap;
  logic [ADDR_W:0] wr_nx, rd_nx;
  assign cmd_wr_req = state == WR_REQ;
  assign cmd_rd_req = state == RD_REQ;
  assign busy = !(state == INIT || state == ARB);
  always_comb begin
    wr_ok = |wr_length && CW'(wr_fifo_usedw) >= CW'(wr_length);
    rd_ok = rd_enable && |rd_length && CW'({FIFO_W{1'b1}} - rd_fifo_usedw) >= CW'(rd_length);
    // a load is held off only while its own direction has a burst outstanding
    wr_apply = wr_pend && state != WR_REQ && state != WR_BUSY;
    rd_apply = rd_pend && state != RD_REQ && state != RD_BUSY;
    arb = state == ARB && !wr_apply && !rd_apply;
    go_wr = arb && wr_ok && (!rd_ok || last_rd);
    go_rd = arb && rd_ok && !go_wr;
    wr_upd = cmd_done && (state == WR_BUSY || (state == WR_REQ && cmd_ack));
    rd_upd = cmd_done && (state == RD_BUSY || (state == RD_REQ && cmd_ack));
    wr_nx = {1'b0, wr_ptr} + (ADDR_W+1)'(cmd_len);
    rd_nx = {1'b0, rd_ptr} + (ADDR_W+1)'(cmd_len);
    wr_wrap = wr_nx >= {1'b0, wr_max_addr};
    rd_wrap = rd_nx >= {1'b0, rd_max_addr};
    state_nx = state;
    case (state)
      INIT:    state_nx = sdram_init_done ? ARB : INIT;
      ARB:     state_nx = go_wr ? WR_REQ : go_rd ? RD_REQ : ARB;
      WR_REQ:  state_nx = !cmd_ack ? WR_REQ : cmd_done ? ARB : WR_BUSY;
      RD_REQ:  state_nx = !cmd_ack ? RD_REQ : cmd_done ? ARB : RD_BUSY;
      WR_BUSY: state_nx = cmd_done ? ARB : WR_BUSY;
      RD_BUSY: state_nx = cmd_done ? ARB : RD_BUSY;
      default: state_nx = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= INIT;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_rd <= 1'b1;
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;
      cmd_addr <= '0;
      cmd_len <= '0;
      frame_write_done <= 1'b0;
      frame_read_done <= 1'b0;
    end else begin
      wr_pend <= (wr_pend && !wr_apply) || wr_load;
      rd_pend <= (rd_pend && !rd_apply) || rd_load;
      frame_write_done <= wr_upd && wr_wrap;
      frame_read_done <= rd_upd && rd_wrap;
      if (wr_apply) wr_ptr <= wr_addr;
      else if (wr_upd) wr_ptr <= wr_wrap ? wr_addr : wr_nx[ADDR_W-1:0];
      if (rd_apply) rd_ptr <= rd_addr;
      else if (rd_upd) rd_ptr <= rd_wrap ? rd_addr : rd_nx[ADDR_W-1:0];
      if (go_wr || go_rd) begin
        last_rd <= go_rd;
        cmd_addr <= go_rd ? rd_ptr : wr_ptr;
        cmd_len <= go_rd ? rd_length : wr_length;
      end
    end
endmodule
